// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO and raises the
// pipeline stall while a mult/div result is being produced.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        md_signal,
    input  logic [2:0]  md_control,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   pending_hi_q, pending_hi_d;
    logic [DATA_W-1:0]   pending_lo_q, pending_lo_d;
    logic                pending_wr_q, pending_wr_d;

    logic [2*DATA_W-1:0] mul_s, mul_u;
    logic                div_zero, div_ovf;
    logic [DATA_W-1:0]   sdivisor, udivisor;
    logic [DATA_W-1:0]   sdiv_q, sdiv_r, udiv_q, udiv_r;

    // Operand arithmetic; divisors are forced to 1 where the hardware divider would misbehave
    always_comb begin
        mul_s    = 64'($signed({{DATA_W{src_a[DATA_W-1]}}, src_a}) *
                       $signed({{DATA_W{src_b[DATA_W-1]}}, src_b}));
        mul_u    = {32'd0, src_a} * {32'd0, src_b};
        div_zero = (src_b == 32'd0);
        div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
        sdivisor = (div_zero || div_ovf) ? 32'd1 : src_b;
        udivisor = div_zero ? 32'd1 : src_b;
        sdiv_q   = 32'($signed(src_a) / $signed(sdivisor));
        sdiv_r   = 32'($signed(src_a) % $signed(sdivisor));
        udiv_q   = src_a / udivisor;
        udiv_r   = src_a % udivisor;
    end

    // Next-state: start/latch in IDLE, count down and commit in RUN
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_wr_d = pending_wr_q;
        case (state_q)
            IDLE: begin
                if (md_signal) begin
                    case (md_control)
                        3'd0, 3'd1: begin
                            pending_hi_d = (md_control == 3'd0) ? mul_s[63:32] : mul_u[63:32];
                            pending_lo_d = (md_control == 3'd0) ? mul_s[31:0]  : mul_u[31:0];
                            pending_wr_d = 1'b1;
                            cnt_d        = CNT_W'(MULT_CYCLES);
                            state_d      = RUN;
                        end
                        3'd2, 3'd3: begin
                            pending_hi_d = (md_control == 3'd2) ? sdiv_r : udiv_r;
                            pending_lo_d = (md_control == 3'd2) ? sdiv_q : udiv_q;
                            pending_wr_d = ~div_zero;
                            cnt_d        = CNT_W'(DIV_CYCLES);
                            state_d      = RUN;
                        end
                        3'd4:    hi_d = src_a;
                        3'd5:    lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (pending_wr_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                    pending_wr_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            pending_hi_q <= '0;
            pending_lo_q <= '0;
            pending_wr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_wr_q <= pending_wr_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == RUN);

    // Stall also covers the start cycle so the following instruction is held
    assign md_stall = busy | (md_signal & ~busy & (md_control <= 3'd3));

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage.
- Consumes the md_signal / md_control / Qa / Qb fields delivered by the ID/EX pipeline register.
- Holds the HI/LO architectural registers.
- Generates the stall2 back-pressure that freezes fetch/decode and inserts bubbles into ID/EX while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-31)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-31)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
md_signal  in  1  EX stage holds a valid HI/LO-writing instruction this cycle
md_control  in  3  op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op)
src_a  in  32  forwarded rs operand
src_b  in  32  forwarded rt operand
hi  out  32  HI register (registered)
lo  out  32  LO register (registered)
busy  out  1  operation in flight (registered)
md_stall  out  1  stall request to pipeline (stall2); combinational

Behaviour:
- Reset (async, active-low): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; HI/LO stay 0; no late commit.
- States: IDLE (busy=0), RUN (busy=1). 5-bit down-counter cnt.
- Start condition: md_signal=1 and busy=0, sampled on a rising edge.
- IDLE, start with op 0-3:
  - Latch the 64-bit result into pending_hi/pending_lo at that edge, computed from src_a/src_b.
  - cnt<=MULT_CYCLES or DIV_CYCLES; busy<=1; go to RUN.
- IDLE, start with op 4/5: hi<=src_a (mthi) or lo<=src_a (mtlo) on that edge; busy stays 0; zero latency.
- IDLE, start with op 6/7: no state change.
- RUN: cnt decrements each edge. On the edge where cnt==1: hi<=pending_hi, lo<=pending_lo, busy<=0, cnt<=0, return to IDLE.
- Cycle counts:
  - busy is high for exactly N cycles after the start edge.
  - New HI/LO are visible in the first cycle busy reads 0.
  - A dependent mfhi/mflo stalled by md_stall reads the new value.
- Start while busy: md_signal ignored, no restart, no queueing. The pipeline guarantees this cannot occur while md_stall is honoured.
- md_stall = busy | (md_signal & ~busy & (md_control<=3)). It asserts in the start cycle itself, so the following instruction is held.
- Arithmetic:
  - mult: {hi,lo} = signed(src_a) * signed(src_b), full 64-bit two's complement.
  - multu: unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (src_b==0, div or divu): full busy latency still applies; HI/LO left unchanged at commit.
- The operands are captured at the start edge. Later changes on src_a/src_b, or bubbles injected into ID/EX, do not affect the result.

Test Plan:
- Reset low then high; mult src_a=0xFFFFFFFD (-3), src_b=7 -> md_stall=1 in the start cycle; busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=0, md_stall=0.
- multu src_a=0xFFFFFFFF, src_b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE. Driving src_a=0 during RUN does not change the result.
- div src_a=0xFFFFFFF9 (-7), src_b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu src_a=7, src_b=2 -> lo=3, hi=1.
- Preload via mthi 0x12345678 and mtlo 0x9ABCDEF0 (each takes effect the same edge, busy stays 0). Then div by src_b=0 -> busy 10 cycles; hi/lo remain 0x12345678 / 0x9ABCDEF0.
- Start mult; reassert md_signal with op=div at cycle 2 of RUN -> ignored; commit at cycle 5 carries the mult result; busy drops once.
- Start div; pull reset low at cycle 4 -> hi=lo=0 and busy=0 immediately. After release, no commit occurs and md_stall=0.
